vedic_mult_pipe: RTL and testbench
==================================

// Module: vedic_mult_pipe
// PURPOSE
//  Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier with per-operation signed/unsigned mode.
//  Operands are split into halves; four half-width products are combined by shifted adds.
//  Valid/ready on both sides; fixed 3-cycle latency when not stalled.
//  Drop-in MAC-datapath multiplier for the PE array, replacing the combinational, enable-gated 16x16 unit.
// PARAMETERS
//  WIDTH    16  operand width; power of two, 8..32; product is 2*WIDTH bits
//  TAG_W    4   width of a sideband tag carried alongside each operation (>=1)
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  reset      in   1          synchronous, active-high
//  in_valid   in   1          operands/mode/tag valid
//  in_ready   out  1          stage 1 can accept this cycle
//  in_a       in   WIDTH      multiplicand
//  in_b       in   WIDTH      multiplier
//  in_signed  in   1          1: two's-complement operands; 0: unsigned
//  in_tag     in   TAG_W      returned unchanged with the result
//  out_valid  out  1          out_prod/out_tag valid
//  out_ready  in   1          consumer accepts the result
//  out_prod   out  2*WIDTH    product (signed or unsigned per in_signed of that operation)
//  out_tag    out  TAG_W      tag of that operation
// BEHAVIOUR
//  - Reset: one clock with reset high clears all stage valids; out_valid=0; out_prod=0 and out_tag=0; in_ready=1 the cycle after.
//    Operations in flight when reset asserts are discarded, with no output.
//  - Transfer occurs on a clock edge where valid&ready are both high.
//  - S1 (on accept):
//    - signed: register |a|, |b| (WIDTH-bit unsigned), sign = a[MSB]^b[MSB]; unsigned: operands as-is, sign=0.
//    - |MIN| = 2^(WIDTH-1) fits in WIDTH bits unsigned.
//  - S2: register the four half products: ll=aL*bL, hl=aH*bL, lh=aL*bH, hh=aH*bH (each WIDTH bits).
//  - S3: register p = hh<<WIDTH + (hl+lh)<<(WIDTH/2) + ll (2*WIDTH bits, no overflow possible).
//    If sign=1, out_prod = -p (two's complement); otherwise out_prod = p.
//  - Latency: result is visible with out_valid=1 exactly 3 cycles after the accepting edge.
//  - Back-to-back operations: one result per cycle.
//  - Stall:
//    - Global stall when out_valid & !out_ready: all stages hold; in_ready=0 (in_ready = !out_valid | out_ready).
//    - out_prod and out_tag hold stable while out_valid=1 and out_ready=0.
//    - Bubbles (invalid stages) still advance only on the global enable; no bubble collapsing required.
//  - Mode and tag are captured per operation; mixing signed and unsigned in consecutive cycles is legal.
//  - Boundaries (WIDTH=16):
//    - 0 x anything = 0 in both modes; in signed mode the result is +0, never negative zero.
//    - MIN x MIN signed = 2^(2*WIDTH-2).
//    - 0xFFFF x 0xFFFF unsigned = 0xFFFE0001.
//  - No tri-state outputs; a consumer that does not want results holds out_ready=0.
// STRUCTURE
//  - Package vedic_pkg: localparam helpers HALF(W)=W/2, PROD_W(W)=2*W; typedef of the stage record
//    {valid, sign, tag}; WIDTH legality check (elaboration $error if not power of two in 8..32).
//  - Sub-module vedic_base_mult #(W): combinational W x W -> 2W unsigned product, instantiated 4x at W=WIDTH/2.
//    Its internals are free, e.g. recursive Vedic or '*'.
//  - Pipeline registers, stall enable and sign fix-up live in vedic_mult_pipe.
// TESTING (WIDTH=16, TAG_W=4; scoreboard vs a*b reference model)
//  1 unsigned 0x1234 x 0x5678, tag 3, out_ready=1 -> 3 cycles later out_prod=0x06260060, out_tag=3.
//  2 unsigned 0xFFFF x 0xFFFF -> 0xFFFE0001.
//    signed 0xFFFF x 0x0001 -> 0xFFFFFFFF.
//    signed 0x8000 x 0x8000 -> 0x40000000.
//  3 20 consecutive random ops, mode alternating each cycle -> 20 results in order, one per cycle, all match the model.
//  4 out_ready=0 for 5 cycles with 3 ops in flight:
//    - out_valid stays 1 with out_prod stable; in_ready=0.
//    - Release out_ready -> remaining results drain in order with no loss or duplication.
//  5 reset asserted with 2 ops in flight -> next cycle out_valid=0, out_prod=0.
//    No stale result ever appears; the new op after reset returns correctly.
//  6 Random valid/ready throttling, 10k ops, WIDTH=8 and WIDTH=32 builds -> zero mismatches.

Source files
------------

// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared helpers and stage record for the pipelined Vedic multiplier
package vedic_pkg;

  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // Operand width must be a power of two in 8..32 so the halves split evenly.
  function automatic bit width_ok(input int w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

  // Per-stage control; the tag travels beside it because its width is a module parameter.
  typedef struct packed {
    logic valid;
    logic sign;
  } stage_ctrl_t;

endpackage

// File: rtl/vedic_base_mult.sv
// rtl/vedic_base_mult.sv - combinational W x W -> 2W unsigned half-width product
module vedic_base_mult #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

// File: rtl/vedic_mult_pipe.sv
// rtl/vedic_mult_pipe.sv - 3-stage valid/ready Vedic multiplier with per-op signed mode and tag
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int H  = half_w(WIDTH);
  localparam int PW = prod_w(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("vedic_mult_pipe: WIDTH must be a power of two in 8..32");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("vedic_mult_pipe: TAG_W must be at least 1");
  end

  stage_ctrl_t       s1, s2, s3;
  logic [TAG_W-1:0]  tag1, tag2, tag3;
  logic [WIDTH-1:0]  a1, b1;
  logic [WIDTH-1:0]  ll, hl, lh, hh;
  logic [WIDTH-1:0]  ll_c, hl_c, lh_c, hh_c;
  logic [PW-1:0]     prod;
  logic [WIDTH-1:0]  a_abs, b_abs;
  logic [WIDTH:0]    mid;
  logic [PW-1:0]     p_sum;
  logic              en;

  // The whole pipe moves together; a held result freezes every stage behind it.
  assign en        = !s3.valid || out_ready;
  assign in_ready  = en;
  assign out_valid = s3.valid;
  assign out_prod  = prod;
  assign out_tag   = tag3;

  // Negating MIN yields 2^(WIDTH-1), which is still correct read as unsigned.
  assign a_abs = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign b_abs = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;

  vedic_base_mult #(.W(H)) u_ll (.a(a1[H-1:0]),     .b(b1[H-1:0]),     .p(ll_c));
  vedic_base_mult #(.W(H)) u_hl (.a(a1[WIDTH-1:H]), .b(b1[H-1:0]),     .p(hl_c));
  vedic_base_mult #(.W(H)) u_lh (.a(a1[H-1:0]),     .b(b1[WIDTH-1:H]), .p(lh_c));
  vedic_base_mult #(.W(H)) u_hh (.a(a1[WIDTH-1:H]), .b(b1[WIDTH-1:H]), .p(hh_c));

  // Cross terms sit H bits up; hh and ll occupy disjoint halves so they concatenate.
  assign mid   = {1'b0, hl} + {1'b0, lh};
  assign p_sum = {hh, ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      tag1 <= '0;
      tag2 <= '0;
      tag3 <= '0;
      prod <= '0;
    end else if (en) begin
      s1.valid <= in_valid;
      s1.sign  <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      if (in_valid) begin
        a1   <= a_abs;
        b1   <= b_abs;
        tag1 <= in_tag;
      end

      s2 <= s1;
      if (s1.valid) begin
        ll   <= ll_c;
        hl   <= hl_c;
        lh   <= lh_c;
        hh   <= hh_c;
        tag2 <= tag1;
      end

      s3 <= s2;
      if (s2.valid) begin
        prod <= s2.sign ? -p_sum : p_sum;
        tag3 <= tag2;
      end
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb/tb_vedic_mult_pipe.sv - directed self-checking bench for vedic_mult_pipe at WIDTH=16
module tb_vedic_mult_pipe;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              in_signed;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic [TAG_W-1:0]  out_tag;

  int n_assert = 0;
  int n_fail   = 0;

  vedic_mult_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [3:0] t);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = t;
  endtask

  // One isolated op; latency counts edges from (and including) the accepting edge.
  task automatic run_single(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic [3:0] t, input logic [31:0] exp);
    int lat;
    drive(a, b, s, t);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd3);
    chk({name, "_prod"}, 64'(out_prod), 64'(exp));
    chk({name, "_tag"}, 64'(out_tag), 64'(t));
    tick();
  endtask

  logic [15:0] va [6];
  logic [15:0] vb [6];
  logic        vs [6];
  logic [31:0] ve [6];
  int          got;
  int          first_cyc;
  int          last_cyc;
  int          stale;
  logic [31:0] held;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_prod", 64'(out_prod), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Basic product and boundaries.
    run_single("u_1234x5678", 16'h1234, 16'h5678, 1'b0, 4'd3, 32'h06260060);
    run_single("u_ffffxffff", 16'hFFFF, 16'hFFFF, 1'b0, 4'd1, 32'hFFFE0001);
    run_single("s_ffffx0001", 16'hFFFF, 16'h0001, 1'b1, 4'd2, 32'hFFFFFFFF);
    run_single("s_minxmin",   16'h8000, 16'h8000, 1'b1, 4'd4, 32'h40000000);
    run_single("u_8000x8000", 16'h8000, 16'h8000, 1'b0, 4'd5, 32'h40000000);
    run_single("s_7fffx8000", 16'h7FFF, 16'h8000, 1'b1, 4'd6, 32'hC0008000);
    run_single("s_0x8000",    16'h0000, 16'h8000, 1'b1, 4'd7, 32'h00000000);
    run_single("s_ffffx0",    16'hFFFF, 16'h0000, 1'b1, 4'd8, 32'h00000000);
    run_single("u_0xffff",    16'h0000, 16'hFFFF, 1'b0, 4'd9, 32'h00000000);
    run_single("s_3xfffe",    16'h0003, 16'hFFFE, 1'b1, 4'hA, 32'hFFFFFFFA);

    // Back-to-back ops, mode alternating every cycle.
    va[0] = 16'h0002; vb[0] = 16'h0003; vs[0] = 1'b0; ve[0] = 32'h00000006;
    va[1] = 16'hFFFE; vb[1] = 16'h0003; vs[1] = 1'b1; ve[1] = 32'hFFFFFFFA;
    va[2] = 16'h0100; vb[2] = 16'h0100; vs[2] = 1'b0; ve[2] = 32'h00010000;
    va[3] = 16'h8000; vb[3] = 16'h0001; vs[3] = 1'b1; ve[3] = 32'hFFFF8000;
    va[4] = 16'h00FF; vb[4] = 16'h00FF; vs[4] = 1'b0; ve[4] = 32'h0000FE01;
    va[5] = 16'h0010; vb[5] = 16'hFFF0; vs[5] = 1'b1; ve[5] = 32'hFFFFFF00;
    got = 0;
    first_cyc = -1;
    last_cyc = -1;
    for (int c = 0; c < 12; c++) begin
      if (c < 6) drive(va[c], vb[c], vs[c], 4'(c));
      else in_valid = 1'b0;
      tick();
      if (out_valid) begin
        if (got < 6) begin
          chk($sformatf("b2b_prod%0d", got), 64'(out_prod), 64'(ve[got]));
          chk($sformatf("b2b_tag%0d", got), 64'(out_tag), 64'(got));
        end
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        got++;
      end
    end
    chk("b2b_count", 64'(got), 64'd6);
    chk("b2b_first_cycle", 64'(first_cyc), 64'd2);
    chk("b2b_consecutive", 64'(last_cyc - first_cyc), 64'd5);

    // Stall with three ops in flight.
    out_ready = 1'b0;
    va[0] = 16'h0007; vb[0] = 16'h0009; vs[0] = 1'b0; ve[0] = 32'h0000003F;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vs[1] = 1'b1; ve[1] = 32'h00000001;
    va[2] = 16'h1000; vb[2] = 16'h0010; vs[2] = 1'b0; ve[2] = 32'h00010000;
    for (int c = 0; c < 3; c++) begin
      drive(va[c], vb[c], vs[c], 4'(c + 11));
      tick();
    end
    in_valid = 1'b0;
    held = out_prod;
    chk("stall_first_prod", 64'(held), 64'(ve[0]));
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall_valid%0d", c), 64'(out_valid), 64'd1);
      chk($sformatf("stall_prod%0d", c), 64'(out_prod), 64'(ve[0]));
      chk($sformatf("stall_in_ready%0d", c), 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) begin
        if (got < 3) begin
          chk($sformatf("drain_prod%0d", got), 64'(out_prod), 64'(ve[got]));
          chk($sformatf("drain_tag%0d", got), 64'(out_tag), 64'(got + 11));
        end
        got++;
      end
      tick();
    end
    chk("drain_count", 64'(got), 64'd3);

    // Reset with two ops in flight discards them.
    drive(16'h0123, 16'h0456, 1'b0, 4'd1);
    tick();
    drive(16'h8001, 16'h0002, 1'b1, 4'd2);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_flight_out_valid", 64'(out_valid), 64'd0);
    chk("rst_flight_out_prod", 64'(out_prod), 64'd0);
    chk("rst_flight_in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) stale++;
      tick();
    end
    chk("rst_no_stale", 64'(stale), 64'd0);
    run_single("post_reset", 16'h0005, 16'h0006, 1'b0, 4'd9, 32'h0000001E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
